lutram_fifo32: RTL



---
 rtl/lutram_fifo32.sv | 85 ++++++++
 1 files changed

// File: rtl/lutram_fifo32.sv
// lutram_fifo32: 32-entry single-clock FIFO on distributed RAM with a
// registered valid/ready output stage. Total capacity is 33 words: 32 in
// RAM plus one in the output register.
module lutram_fifo32 #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned AF_THRESH       = 28,
    parameter bit          IS_CLK_INVERTED = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             OVFL,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [5:0]       LEVEL
);

    // A single internal clock net; the optional inversion moves every
    // register in the block to the falling edge of CLK.
    logic clk_int;
    assign clk_int = CLK ^ IS_CLK_INVERTED;

    logic [WIDTH-1:0] mem [0:31];
    logic [4:0]       wptr;
    logic [4:0]       rptr;
    logic [5:0]       cnt;
    logic             push;
    logic             load;

    // Accept a push only while RAM has room; a same-cycle load does not free
    // a slot early, so FULL alone gates pushes.
    assign push = WR_EN & ~FULL;

    // Refill the output register whenever RAM holds data and the register is
    // empty or being consumed this cycle.
    assign load = (cnt != 6'd0) & (~RD_VALID | RD_READY);

    assign FULL        = (cnt == 6'd32);
    assign ALMOST_FULL = (32'(cnt) >= AF_THRESH);
    assign LEVEL       = cnt + 6'(RD_VALID);

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk_int) begin
        if (push) begin
            mem[wptr] <= WR_DATA;
        end
    end

    // Pointers, occupancy, overflow pulse and output register.
    always_ff @(posedge clk_int) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
            OVFL     <= 1'b0;
        end else begin
            OVFL <= WR_EN & FULL;

            if (push) begin
                wptr <= wptr + 5'd1;
            end

            if (load) begin
                RD_DATA  <= mem[rptr];
                rptr     <= rptr + 5'd1;
                RD_VALID <= 1'b1;
            end else if (RD_READY) begin
                RD_VALID <= 1'b0;
            end

            case ({push, load})
                2'b10:   cnt <= cnt + 6'd1;
                2'b01:   cnt <= cnt - 6'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
